// File: rtl/lsu_controller_if.sv
// rtl/lsu_controller_if.sv - core request/response and data-memory signals of the load/store unit
interface lsu_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata, mem_ack,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - single-outstanding load/store sequencer for a single-port data memory
module lsu_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  lsu_controller_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [7:0] TLAST  = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  tcount;
  logic [2:0]  funct3_q;
  logic [1:0]  lo_q;
  logic        legal_f3;
  logic        aligned;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        accept;

  assign bus.req_ready  = (state == IDLE) & ~reset;
  assign bus.resp_valid = (state == RESP);
  assign accept         = bus.req_valid & bus.req_ready;

  always_comb begin
    legal_f3 = 1'b0;
    aligned  = 1'b1;
    st_data  = bus.req_wdata;
    st_strb  = 4'b1111;
    if (bus.req_write)
      legal_f3 = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010);
    else
      legal_f3 = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                 (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                 (bus.req_funct3 == 3'b101);
    case (bus.req_funct3[1:0])
      2'b01:   aligned = ~bus.req_addr[0];
      2'b10:   aligned = (bus.req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    // Narrow stores are replicated across the word so any lane can pick them up
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_data = {4{bus.req_wdata[7:0]}};
        st_strb = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{bus.req_wdata[15:0]}};
        st_strb = 4'b0011 << bus.req_addr[1:0];
      end
      default: begin
        st_data = bus.req_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'h00;
    ld_data = 32'h0;
    case (lo_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      tcount         <= 8'h0;
      funct3_q       <= 3'b000;
      lo_q           <= 2'b00;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_wdata  <= 32'h0;
      bus.mem_wstrb  <= 4'h0;
      bus.resp_rdata <= 32'h0;
      bus.resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q <= bus.req_funct3;
            lo_q     <= bus.req_addr[1:0];
            tcount   <= 8'h0;
            if (legal_f3 && aligned) begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_write;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_wdata <= bus.req_write ? st_data : 32'h0;
              bus.mem_wstrb <= bus.req_write ? st_strb : 4'h0;
              state         <= ACCESS;
            end else begin
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= 32'h0;
              state          <= RESP;
            end
          end
        end
        ACCESS: begin
          // An ack on the last allowed cycle still completes the access
          if (bus.mem_ack) begin
            bus.resp_rdata <= bus.mem_we ? 32'h0 : ld_data;
            bus.resp_error <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            state          <= RESP;
          end else if (tcount == TLAST) begin
            bus.resp_rdata <= 32'h0;
            bus.resp_error <= 1'b1;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            state          <= RESP;
          end else begin
            tcount <= tcount + 8'h1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// tb/tb_lsu_controller.sv - scoreboard bench for lsu_controller
module tb_lsu_controller;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   mem_req_seen = 0;
  exp_t exp_q[$];

  lsu_controller_if bus();

  lsu_controller #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Response monitor: pops the oldest expectation on every resp_valid pulse
  always @(negedge clk) begin
    if (!reset && bus.resp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rdata=%h error=%b required no response",
                 bus.resp_rdata, bus.resp_error);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        check({e.name, "_error"}, {31'h0, bus.resp_error}, {31'h0, e.err});
      end
    end
    if (bus.mem_req) mem_req_seen = 1;
  end

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic push, input logic [31:0] er,
                        input logic ee, input string nm);
    int n;
    if (push) exp_q.push_back('{er, ee, nm});
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept"}, {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic ack_after(input int n, input logic [31:0] d);
    repeat (n) @(negedge clk);
    bus.mem_rdata = d;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check({nm, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bus.req_valid = 0; bus.req_write = 0; bus.req_funct3 = 0; bus.req_addr = 0;
    bus.req_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);

    // LW with two wait cycles
    do_req(0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, "lw");
    check("lw_mem_req", {31'h0, bus.mem_req}, 32'h1);
    check("lw_mem_addr", bus.mem_addr, 32'h100);
    check("lw_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h0);
    check("lw_mem_we", {31'h0, bus.mem_we}, 32'h0);
    ack_after(2, 32'hDEADBEEF);
    drain("lw");

    do_req(0, 3'b000, 32'h103, 32'h0, 1, 32'hFFFFFF80, 0, "lb");
    ack_after(0, 32'h80112233);
    drain("lb");
    do_req(0, 3'b100, 32'h103, 32'h0, 1, 32'h00000080, 0, "lbu");
    ack_after(0, 32'h80112233);
    drain("lbu");
    do_req(0, 3'b001, 32'h102, 32'h0, 1, 32'hFFFF8011, 0, "lh");
    ack_after(1, 32'h80112233);
    drain("lh");
    do_req(0, 3'b101, 32'h100, 32'h0, 1, 32'h00002233, 0, "lhu");
    ack_after(0, 32'h80112233);
    drain("lhu");

    // Stores: lane steering, and rdata must be zero even with junk on mem_rdata
    do_req(1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0, 0, "sh");
    check("sh_mem_addr", bus.mem_addr, 32'h200);
    check("sh_mem_wdata", bus.mem_wdata, 32'hABCDABCD);
    check("sh_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'hC);
    check("sh_mem_we", {31'h0, bus.mem_we}, 32'h1);
    ack_after(1, 32'hFFFFFFFF);
    drain("sh");
    do_req(1, 3'b000, 32'h101, 32'h1234565A, 1, 32'h0, 0, "sb");
    check("sb_mem_wdata", bus.mem_wdata, 32'h5A5A5A5A);
    check("sb_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'h2);
    ack_after(0, 32'hFFFFFFFF);
    drain("sb");
    do_req(1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'h0, 0, "sw");
    check("sw_mem_wdata", bus.mem_wdata, 32'hCAFEF00D);
    check("sw_mem_wstrb", {28'h0, bus.mem_wstrb}, 32'hF);
    ack_after(0, 32'h0);
    drain("sw");

    // Rejected requests never touch memory
    mem_req_seen = 0;
    do_req(0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1, "lw_misaligned");
    check("lw_misaligned_mem_req", {31'h0, bus.mem_req}, 32'h0);
    drain("lw_misaligned");
    do_req(1, 3'b100, 32'h200, 32'h55, 1, 32'h0, 1, "st_bad_f3");
    check("st_bad_f3_mem_req", {31'h0, bus.mem_req}, 32'h0);
    drain("st_bad_f3");
    do_req(0, 3'b001, 32'h103, 32'h0, 1, 32'h0, 1, "lh_misaligned");
    drain("lh_misaligned");
    do_req(0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1, "ld_bad_f3");
    drain("ld_bad_f3");
    check("err_mem_req_never", mem_req_seen, 0);

    // Timeout after 16 ACCESS cycles
    do_req(0, 3'b010, 32'h400, 32'h0, 1, 32'h0, 1, "timeout");
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      cnt++;
      @(negedge clk);
    end
    check("timeout_req_cycles", cnt, 16);
    drain("timeout");

    do_req(0, 3'b010, 32'h404, 32'h0, 1, 32'h12345678, 0, "ack16");
    ack_after(15, 32'h12345678);
    check("ack16_mem_req", {31'h0, bus.mem_req}, 32'h0);
    drain("ack16");

    // An ack while idle is ignored
    @(negedge clk);
    ack_after(0, 32'hFFFF0000);
    check("idle_ack_no_resp", {31'h0, bus.resp_valid}, 32'h0);

    // Reset one cycle into ACCESS abandons the access
    do_req(0, 3'b010, 32'h300, 32'h0, 0, 32'h0, 0, "rst_access");
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_req", {31'h0, bus.mem_req}, 32'h0);
    check("rst_mid_req_ready", {31'h0, bus.req_ready}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_after_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_after_resp_valid", {31'h0, bus.resp_valid}, 32'h0);

    do_req(0, 3'b010, 32'h308, 32'h0, 1, 32'h0BADF00D, 0, "post_rst");
    ack_after(0, 32'h0BADF00D);
    drain("post_rst");

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Sequences every load/store from the core onto the single-port data memory.
- One outstanding access at a time; valid/ready request side, one-cycle response pulse.
- Performs alignment and funct3 checks, store byte-lane steering, and load byte/half extraction with sign or zero extension.
- Handles variable memory latency with a timeout.

Parameters:
- TIMEOUT, 16, number of ACCESS cycles without mem_ack before the access is aborted with error; legal range 2..255.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  controller accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_error  out  1  qualifies resp_valid: misaligned, illegal funct3 or timeout
- mem_req  out  1  memory access request, held until acked
- mem_we  out  1  write enable
- mem_addr  out  32  word address {req_addr[31:2],2'b00}
- mem_wdata  out  32  lane-steered store data
- mem_wstrb  out  4  byte strobes; 0 for loads
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  memory completes the access this cycle

Behaviour:
- Reset: state IDLE.
  - mem_req, mem_we, resp_valid and resp_error are 0.
  - mem_addr, mem_wdata, mem_wstrb, resp_rdata and the timeout counter are 0.
  - req_ready = (state==IDLE) & ~reset, so it is 0 while reset is high.
- Reset mid-operation: the access is abandoned. mem_req is 0 after the edge and no response is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. A request is accepted on an edge where req_valid & req_ready.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Alignment rules:
  - Word accesses need addr[1:0]==0.
  - Halfword accesses need addr[0]==0.
- An accepted request that violates either rule goes to RESP with resp_error=1 and resp_rdata=0. No memory request is issued.
- A legal request goes to ACCESS. On the same edge these are registered: mem_req=1, mem_we=req_write, mem_addr, funct3, addr[1:0], wdata and wstrb.
- Store steering:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=d, wstrb=4'b1111.
- ACCESS: all mem_* outputs are held stable. The timeout counter increments each cycle mem_ack is low.
- On mem_ack:
  - For loads, resp_rdata is extracted from mem_rdata using the latched addr[1:0] and funct3, then registered:
    - LB/LH: sign-extend the selected byte/halfword.
    - LBU/LHU: zero-extend it.
    - LW: the full word.
  - For stores, resp_rdata=0.
  - Then: resp_error=0, mem_req=0, state goes to RESP.
- Timeout: if the counter reaches TIMEOUT-1 with mem_ack low, then mem_req=0, resp_error=1, resp_rdata=0, state goes to RESP. If mem_ack arrives on that same cycle, the ack wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure.
  - resp_rdata and resp_error keep their values until the next response.
  - req_ready=0 in RESP, so minimum spacing is 3 cycles per legal access.
- mem_ack outside ACCESS is ignored. req_valid while req_ready=0 is ignored; the core holds the request.

Test Plan:
- After reset, LW at 0x100; mem acks 2 cycles later with 0xDEADBEEF.
  - Required: mem_addr=0x100, wstrb=0. One resp_valid, rdata=0xDEADBEEF, error=0.
- LB at 0x103; mem_rdata=0x80112233, immediate ack.
  - Required: rdata=0xFFFFFF80.
  - Repeat as LBU: rdata=0x00000080.
- SH at 0x202, wdata=0x0000ABCD.
  - Required: mem_addr=0x200, mem_wdata=0xABCDABCD, wstrb=4'b1100, mem_we=1. Response rdata=0.
- Misaligned LW at 0x101, then illegal store funct3=3'b100.
  - Required: each gives resp_valid with error=1, and mem_req never rises.
- TIMEOUT=16, mem_ack held low.
  - Required: mem_req is high 16 cycles, then drops; resp_valid with error=1.
  - Repeat with ack on the 16th cycle: error=0, data returned.
- Assert reset 1 cycle into ACCESS.
  - Required: mem_req=0 after the edge, no resp_valid, req_ready=1 the cycle after reset deasserts.
